// File: rtl/cva5_types.sv
// cva5_types: shared BTB types; hint fields exist only when BTP_RAS_HINT_EN is defined
package cva5_types;
  localparam int MAX_TAG_W = 24;
  typedef enum logic {INIT, RUN} btp_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target_pc;
    logic        branch_taken;
    logic        is_branch;
    logic        is_return;
    logic        is_call;
  } branch_results_t;
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           counter;
`ifdef BTP_RAS_HINT_EN
    logic                 is_return;
    logic                 is_call;
`endif
  } btb_entry_t;
endpackage

// File: rtl/btb_ram.sv
// btb_ram: one synchronous read port, one write port, read-first
module btb_ram
  import cva5_types::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output btb_entry_t               rdata,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  btb_entry_t               wdata
);
  btb_entry_t mem [DEPTH];
  // a read of the address being written returns the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit counters; RAS hints with BTP_RAS_HINT_EN
module branch_target_predictor
  import cva5_types::*;
#(
  parameter int ENTRIES = 512,
  parameter int TAG_W   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [31:0]     fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic            pred_is_return,
  output logic            pred_is_call,
  input  branch_results_t br_results,
  output logic            init_done
);
  localparam int IDX_W = $clog2(ENTRIES);
  btp_state_t           state;
  logic [IDX_W-1:0]     clear_idx, fetch_idx, br_idx, upd_idx, wa, last_idx;
  logic [MAX_TAG_W-1:0] fetch_tag, upd_tag, ftag_r;
  logic                 fv_r, hit, we, last_we;
  branch_results_t      upd;
  btb_entry_t           look_e, upd_rd, old_e, new_e, wr_e, last_e;
  logic                 unused_bits;
  assign fetch_idx   = fetch_pc[IDX_W+1:2];
  assign fetch_tag   = MAX_TAG_W'(fetch_pc[IDX_W+TAG_W+1:IDX_W+2]);
  assign br_idx      = br_results.pc[IDX_W+1:2];
  assign upd_idx     = upd.pc[IDX_W+1:2];
  assign upd_tag     = MAX_TAG_W'(upd.pc[IDX_W+TAG_W+1:IDX_W+2]);
  assign unused_bits = ^{fetch_pc, br_results.pc, upd};
  // lookup copy and update-read copy hold identical contents, giving the updater its own read port
  btb_ram #(.DEPTH(ENTRIES)) u_look (
    .clk(clk), .raddr(fetch_idx), .rdata(look_e), .we(we), .waddr(wa), .wdata(wr_e)
  );
  btb_ram #(.DEPTH(ENTRIES)) u_upd (
    .clk(clk), .raddr(br_idx), .rdata(upd_rd), .we(we), .waddr(wa), .wdata(wr_e)
  );
  // clearing sequence, lookup pipeline, update capture and write-forwarding history
  always_ff @(posedge clk) begin
    ftag_r   <= fetch_tag;
    last_idx <= wa;
    last_e   <= wr_e;
    if (rst) begin
      state     <= INIT;
      clear_idx <= '0;
      init_done <= 1'b0;
      fv_r      <= 1'b0;
      upd       <= '0;
      last_we   <= 1'b0;
    end else begin
      if (state == INIT) begin
        clear_idx <= clear_idx + 1'b1;
        if (clear_idx == IDX_W'(ENTRIES - 1)) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end
      fv_r      <= fetch_valid && state == RUN;
      upd       <= br_results;
      upd.valid <= br_results.valid && state == RUN;
      last_we   <= we && state == RUN;
    end
  end
  // read-modify-write of the resolved branch; a write to the same index last cycle is forwarded
  always_comb begin
    old_e         = (last_we && last_idx == upd_idx) ? last_e : upd_rd;
    hit           = old_e.valid && old_e.tag == upd_tag;
    new_e         = old_e;
    new_e.valid   = 1'b1;
    new_e.tag     = upd_tag;
    new_e.target  = (upd.branch_taken || !hit) ? upd.target_pc : old_e.target;
    new_e.counter = !upd.is_branch ? 2'd3 :
                    !hit ? 2'd2 :
                    upd.branch_taken ? (old_e.counter == 2'd3 ? 2'd3 : old_e.counter + 2'd1) :
                    (old_e.counter == 2'd0 ? 2'd0 : old_e.counter - 2'd1);
`ifdef BTP_RAS_HINT_EN
    new_e.is_return = upd.is_return;
    new_e.is_call   = upd.is_call;
`endif
    we   = !rst && (state == INIT || (upd.valid && (hit || upd.branch_taken)));
    wa   = state == INIT ? clear_idx : upd_idx;
    wr_e = state == INIT ? '0 : new_e;
  end
  assign pred_valid  = fv_r && look_e.valid && look_e.tag == ftag_r;
  assign pred_taken  = pred_valid && look_e.counter[1];
  assign pred_target = pred_valid ? look_e.target : '0;
`ifdef BTP_RAS_HINT_EN
  assign pred_is_return = pred_valid && look_e.is_return;
  assign pred_is_call   = pred_valid && look_e.is_call;
`else
  assign pred_is_return = 1'b0;
  assign pred_is_call   = 1'b0;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench for branch_target_predictor (ENTRIES=512, TAG_W=12)
module tb_branch_target_predictor;
  import cva5_types::*;
`ifdef BTP_RAS_HINT_EN
  localparam bit HINT = 1'b1;
`else
  localparam bit HINT = 1'b0;
`endif
  typedef struct packed {
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic        r;
    logic        c;
  } pred_t;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            fetch_valid = 1'b0;
  logic [31:0]     fetch_pc = '0;
  branch_results_t br_results = '0;
  logic            pred_valid, pred_taken, pred_is_return, pred_is_call, init_done;
  logic [31:0]     pred_target;
  int              checks = 0;
  int              errors = 0;
  pred_t           sb[$];
  branch_results_t pend = '0;
  logic            m_v [512];
  logic [11:0]     m_tag [512];
  logic [31:0]     m_tgt [512];
  logic [1:0]      m_cnt [512];
  logic            m_r [512];
  logic            m_c [512];

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(512), .TAG_W(12)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_is_return(pred_is_return), .pred_is_call(pred_is_call),
    .br_results(br_results), .init_done(init_done)
  );

  function automatic branch_results_t mk(input logic [31:0] pc, input logic [31:0] tg,
                                         input logic tk, input logic b, input logic r, input logic c);
    branch_results_t u;
    u = '0;
    u.valid = 1'b1;
    u.pc = pc;
    u.target_pc = tg;
    u.branch_taken = tk;
    u.is_branch = b;
    u.is_return = r;
    u.is_call = c;
    return u;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 512; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = '0; m_r[i] = 1'b0; m_c[i] = 1'b0;
    end
    sb.delete();
    pend = '0;
  endfunction

  function automatic void model_apply(input branch_results_t u);
    int i;
    logic [11:0] tg;
    logic h;
    i  = int'(u.pc[10:2]);
    tg = u.pc[22:11];
    h  = m_v[i] && m_tag[i] == tg;
    if (h) begin
      if (!u.is_branch) m_cnt[i] = 2'd3;
      else if (u.branch_taken) m_cnt[i] = (m_cnt[i] == 2'd3) ? 2'd3 : m_cnt[i] + 2'd1;
      else m_cnt[i] = (m_cnt[i] == 2'd0) ? 2'd0 : m_cnt[i] - 2'd1;
      if (u.branch_taken) m_tgt[i] = u.target_pc;
      m_r[i] = u.is_return;
      m_c[i] = u.is_call;
    end else if (u.branch_taken) begin
      m_v[i] = 1'b1;
      m_tag[i] = tg;
      m_tgt[i] = u.target_pc;
      m_cnt[i] = u.is_branch ? 2'd2 : 2'd3;
      m_r[i] = u.is_return;
      m_c[i] = u.is_call;
    end
  endfunction

  function automatic pred_t model_look(input logic fv, input logic [31:0] pc);
    pred_t p;
    int i;
    p = '0;
    i = int'(pc[10:2]);
    if (fv && m_v[i] && m_tag[i] == pc[22:11]) begin
      p.v = 1'b1;
      p.t = m_cnt[i][1];
      p.tgt = m_tgt[i];
      p.r = HINT & m_r[i];
      p.c = HINT & m_c[i];
    end
    return p;
  endfunction

  // one cycle of stimulus: expectation from the table before this edge's write, then retire the pending update
  task automatic step(input logic fv, input logic [31:0] pc, input branch_results_t br);
    @(negedge clk);
    fetch_valid = fv;
    fetch_pc = pc;
    br_results = br;
    sb.push_back(model_look(fv, pc));
    if (pend.valid) model_apply(pend);
    pend = br;
  endtask

  task automatic flush();
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
  endtask

  always @(posedge clk) begin
    pred_t e, a;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {pred_valid, pred_taken, pred_target, pred_is_return, pred_is_call};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_pred got v=%0b t=%0b tgt=%h r=%0b c=%0b exp v=%0b t=%0b tgt=%h r=%0b c=%0b",
                 a.v, a.t, a.tgt, a.r, a.c, e.v, e.t, e.tgt, e.r, e.c);
      end
    end
  end

  task automatic test_reset(input int pre);
    int cyc;
    logic bad;
    @(negedge clk);
    rst = 1'b1;
    fetch_valid = 1'b1;
    fetch_pc = 32'h1000;
    br_results = mk(32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    if (pre > 0) begin
      rst = 1'b0;
      repeat (pre) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (init_done !== 1'b0 || pred_valid !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got init_done=%0b pred_valid=%0b tgt=%h exp 0 0 0", init_done, pred_valid, pred_target);
    end
    model_clear();
    rst = 1'b0;
    cyc = 0;
    bad = 1'b0;
    while (!init_done && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pred_valid) bad = 1'b1;
    end
    fetch_valid = 1'b0;
    br_results = '0;
    checks++;
    if (cyc != 512) begin
      errors++;
      $display("FAIL init_cycles got %0d exp 512", cyc);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL init_pred_valid got 1 exp 0");
    end
    step(1'b1, 32'h1000, '0);
    flush();
  endtask

  task automatic test_taken_hit();
    step(1'b0, '0, mk(32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h1000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h2000) begin
      errors++;
      $display("FAIL taken_hit got v=%0b t=%0b tgt=%h exp 1 1 00002000", pred_valid, pred_taken, pred_target);
    end
    flush();
  endtask

  task automatic test_counter();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, mk(32'h1000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
      step(1'b1, 32'h1000, '0);
      step(1'b1, 32'h1000, '0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL counter_floor got v=%0b t=%0b exp 1 0", pred_valid, pred_taken);
    end
    step(1'b0, '0, mk(32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h1000, '0);
    flush();
  endtask

  task automatic test_miss_nt();
    step(1'b0, '0, mk(32'h3000, 32'h3100, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h3000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b0 || pred_target !== 32'h0) begin
      errors++;
      $display("FAIL miss_nt got v=%0b tgt=%h exp 0 00000000", pred_valid, pred_target);
    end
    flush();
  endtask

  task automatic test_alias();
    step(1'b0, '0, mk(32'h1800, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h1000, '0);
    step(1'b1, 32'h1800, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h5000) begin
      errors++;
      $display("FAIL alias got v=%0b tgt=%h exp 1 00005000", pred_valid, pred_target);
    end
    flush();
  endtask

  task automatic test_same_cycle();
    step(1'b0, '0, mk(32'h1000, 32'h2000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b0, '0, mk(32'h1000, 32'h7000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b1, 32'h1000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h2000) begin
      errors++;
      $display("FAIL read_first_old got v=%0b tgt=%h exp 1 00002000", pred_valid, pred_target);
    end
    step(1'b1, 32'h1000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_target !== 32'h7000) begin
      errors++;
      $display("FAIL read_first_new got v=%0b tgt=%h exp 1 00007000", pred_valid, pred_target);
    end
    flush();
  endtask

  task automatic test_back_to_back();
    step(1'b0, '0, mk(32'h2400, 32'h9000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, mk(32'h2400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h2400, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL b2b_alloc_fwd got v=%0b t=%0b exp 1 0", pred_valid, pred_taken);
    end
    step(1'b0, '0, mk(32'h2400, 32'h9000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, mk(32'h2400, 32'h9000, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, mk(32'h2400, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h2400, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL b2b_counter_fwd got v=%0b t=%0b exp 1 1", pred_valid, pred_taken);
    end
    flush();
  endtask

  task automatic test_jal();
    step(1'b0, '0, mk(32'h4000, 32'h8000, 1'b1, 1'b0, 1'b0, 1'b1));
    step(1'b0, '0, '0);
    step(1'b1, 32'h4000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_is_call !== HINT || pred_is_return !== 1'b0) begin
      errors++;
      $display("FAIL jal_hint got v=%0b t=%0b call=%0b ret=%0b exp 1 1 %0b 0",
               pred_valid, pred_taken, pred_is_call, pred_is_return, HINT);
    end
    step(1'b0, '0, mk(32'h4000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step(1'b0, '0, '0);
    step(1'b1, 32'h4000, '0);
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL jal_counter3 got v=%0b t=%0b exp 1 1", pred_valid, pred_taken);
    end
    flush();
  endtask

  task automatic test_random();
    logic [31:0] pcs [6];
    branch_results_t u;
    pcs = '{32'h1000, 32'h1800, 32'h3000, 32'h2400, 32'h4000, 32'h1004};
    for (int n = 0; n < 300; n++) begin
      u = '0;
      if ($urandom_range(0, 1) == 1)
        u = mk(pcs[$urandom_range(0, 5)], $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)], u);
    end
    flush();
  endtask

  initial begin
    test_reset(0);
    test_taken_hit();
    test_counter();
    test_miss_nt();
    test_alias();
    test_same_cycle();
    test_back_to_back();
    test_jal();
    test_random();
    test_reset(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 512, number of table entries (power of two, 64..4096).
REQ-002 SHALL have parameter TAG_W, default 12, stored tag width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port fetch_valid, input, 1, lookup request this cycle.
REQ-006 SHALL have port fetch_pc, input, 32, PC to look up.
REQ-007 SHALL have port pred_valid, output, 1, table hit for the previous cycle's lookup.
REQ-008 SHALL have port pred_taken, output, 1, predicted direction.
REQ-009 SHALL have port pred_target, output, 32, predicted target PC.
REQ-010 SHALL have ports pred_is_return and pred_is_call, output, 1 each, RAS hints.
REQ-011 SHALL have port br_results, input, branch_results_t, resolved-branch packet from the branch unit (valid, pc, target_pc, branch_taken, is_branch, is_return, is_call).
REQ-012 SHALL have port init_done, output, 1, high once table clearing has completed.

Function
REQ-013 SHALL use a two-state FSM: INIT → RUN when the clear index reaches ENTRIES-1; RUN → INIT only on rst.
REQ-014 In INIT SHALL clear one entry's valid bit per cycle, index 0 upward, taking exactly ENTRIES cycles.
REQ-015 In INIT SHALL hold pred_valid=0 and init_done=0, and SHALL drop br_results.
REQ-016 SHALL form index = pc[log2(ENTRIES)+1:2] and tag = pc[log2(ENTRIES)+TAG_W+1:log2(ENTRIES)+2].
REQ-017 Lookup latency SHALL be one cycle: fetch_pc sampled at cycle N, pred_* valid at cycle N+1.
REQ-018 pred_valid SHALL be 1 only if the previous cycle had fetch_valid, the entry is valid, and the tags match.
REQ-019 When pred_valid=0, all other pred_* outputs SHALL be 0.
REQ-020 pred_taken SHALL equal bit 1 of the entry's 2-bit counter.
REQ-021 An update SHALL be registered: br_results.valid sampled at cycle N, table written at cycle N+1.
REQ-022 On a hit update, the counter SHALL increment if taken and decrement if not taken, saturating at 3 and 0.
REQ-023 On a hit update with taken=1, the target SHALL be overwritten with target_pc.
REQ-024 On a miss update with taken=1, the entry SHALL be allocated (overwriting any alias): valid=1, new tag, target, counter=2.
REQ-025 A miss update with taken=0 SHALL NOT allocate.
REQ-026 An update with is_branch=0 (jump) SHALL force the counter to 3.
REQ-027 A lookup and a write to the same index in the same cycle SHALL return the old entry (read-first); the next lookup SHALL see the new entry.
REQ-028 Back-to-back updates to the same index SHALL both take effect in order; the second SHALL use the first's result (write-forwarding of the counter).

Reset
REQ-029 On rst: state=INIT, clear index=0, init_done=0, pred_*=0, and any pending update discarded.
REQ-030 rst asserted mid-INIT or mid-RUN SHALL restart clearing from index 0.

Configuration
REQ-031 With BTP_RAS_HINT_EN defined, is_return/is_call bits SHALL be stored per entry and driven on pred_is_return/pred_is_call.
REQ-032 Without BTP_RAS_HINT_EN, those bits SHALL NOT be stored, and both outputs SHALL be tied to 0.

Structure
REQ-033 The btb_entry_t typedef (valid, tag, target, counter, optional hints) SHALL reside in cva5_types.
REQ-034 Storage SHALL be a sub-module btb_ram: one synchronous read port, one write port, read-first behaviour.

Verification
REQ-035 Apply rst, then release -> init_done rises exactly ENTRIES (512) cycles later; pred_valid=0 throughout.
REQ-036 Taken update pc=0x1000, target=0x2000; then lookup 0x1000 -> next cycle pred_valid=1, pred_taken=1, pred_target=0x2000.
REQ-037 Three not-taken updates to 0x1000 after allocation -> counter 2→1→0→0; pred_taken=0.
REQ-038 Not-taken update on miss pc=0x3000, then lookup -> pred_valid=0.
REQ-039 Alias: allocate 0x1000, then taken update 0x1800 (same index, different tag) -> lookup 0x1000 misses, 0x1800 hits.
REQ-040 Same-cycle write and lookup of 0x1000 -> old data returned; lookup on the following cycle returns new data; a JAL update (is_branch=0, is_call=1) with BTP_RAS_HINT_EN defined -> pred_is_call=1, counter=3.
